ltc2308_emulator: RTL and testbench
===================================

# ltc2308_emulator

Synthesizable emulation of the LTC2308 8-channel, 12-bit SPI ADC. It is the responder end of the CONVST/SCK/SDI/SDO interface. The block sits on the FPGA in place of the physical ADC, either looped back to the ADC controller or driven out to a header, so drone sensor firmware and the controller can be exercised with known sample values. It decodes the 6-bit config word and returns the selected channel's 12-bit code MSB-first, with the LTC2308 rule that a config word applies to the next conversion.

## Interface
- `CONV_CYCLES`, default 64: emulator-clock cycles the conversion is busy after the CONVST rising edge is detected. Legal range is 1..1023.
- `clk`  in  1  emulator clock. Frequency must be ≥ 8× the SCK frequency.
- `reset`  in  1  asynchronous, active-high reset.
- `adc_convst`  in  1  CONVST from the master. It is asynchronous to `clk`.
- `adc_sck`  in  1  SCK from the master. It is asynchronous to `clk`.
- `adc_sdi`  in  1  SDI config bit from the master. It is asynchronous to `clk`.
- `adc_sdo`  out  1  serial data to the master.
- `sample_data`  in  96  channel codes; channel n is `sample_data[12n+11:12n]`.
- `cfg_ch`  out  3  active channel, `{S1,S0,O/S}`.
- `cfg_diff`  out  1  active mode is differential (S/D = 0).
- `cfg_uni`  out  1  active mode is unipolar.
- `cfg_slp`  out  1  active SLP bit.
- `conv_busy`  out  1  high while the block is in state CONV.
- `frame_done`  out  1  one-cycle pulse when a 12-bit frame completes.
- `proto_err`  out  1  one-cycle pulse when an SCK edge arrives outside SHIFT.

## Operation
- Input synchronization:
  - `adc_convst`, `adc_sck` and `adc_sdi` each pass through a 2-flop synchronizer.
  - A third flop on CONVST and on SCK provides rise/fall edge detect.
  - SDI is sampled from its synchronized value on each synced SCK rising edge.
- Active config register, 6 bits `{S/D,O/S,S1,S0,UNI,SLP}`:
  - Reset value is 6'b100010 (ch0, single-ended, unipolar, no sleep).
  - The `cfg_*` outputs decode this register combinationally.
- State IDLE:
  - `adc_sdo` = 0.
  - CONVST rise: capture code = `sample_data` of `cfg_ch`. If UNI = 0, bit 11 of the code is inverted. Load the busy counter with CONV_CYCLES and go to CONV.
  - SCK edge (rise or fall): pulse `proto_err`. No other effect.
- State CONV:
  - `conv_busy` = 1 and `adc_sdo` = 0.
  - The counter decrements each cycle. At 0, go to SHIFT with `adc_sdo` = code[11] and bit index = 11.
  - SCK edge: pulse `proto_err`. Any CONVST edge is ignored.
- State SHIFT:
  - SCK rise: while fewer than 6 rises have been seen, shift the synced SDI into the pending config register, MSB first.
  - SCK fall: decrement the bit index and drive `adc_sdo` = code[index].
  - The 12th fall ends the frame: `adc_sdo` = 0, pulse `frame_done`, go to IDLE.
  - On frame end, the pending config is copied to the active config if 6 rises were seen.
- CONVST rise during SHIFT aborts the frame:
  - No `frame_done` pulse.
  - The pending config is committed only if 6 rises were already seen.
  - The block then behaves exactly as a CONVST rise in IDLE, using the config just committed (if any).
- A CONVST rise and an SCK edge on the same cycle: CONVST wins and the SCK edge is discarded.
- SLP is recorded and reported only; the emulator never sleeps.
- `reset` asserted at any time (including mid-frame):
  - State returns to IDLE.
  - `adc_sdo`, `conv_busy`, `frame_done` and `proto_err` go to 0.
  - The active config returns to 6'b100010 and the pending config is cleared.

## Timing
- Input latency: 3 `clk` cycles from a pin edge to its detect pulse.
- `conv_busy` rises 4 cycles after the CONVST pin rises. It falls, and `adc_sdo` presents bit 11, CONV_CYCLES cycles later.
- `adc_sdo` changes 4 `clk` cycles after each SCK pin falling edge. The master samples on SCK falling edges and therefore receives the previous bit, matching LTC2308 behaviour.
- `frame_done` and the config commit occur in the same cycle, 4 cycles after the 12th SCK fall.
- Constraint: SCK high and low times must each be ≥ 4 `clk` cycles.

## Test plan
- Basic frame:
  - Stimulus: reset; ch0 = 0xABC; CONVST pulse; wait for `conv_busy` to fall; 12 SCK with SDI = 110010.
  - Required response: master reads 0xABC; one `frame_done` pulse; `cfg_ch` = 1, `cfg_uni` = 1.
- Config applies to the next conversion:
  - Stimulus: ch1 = 0x123; next frame with SDI = 100000.
  - Required response: read 0x123; then `cfg_uni` = 0 and `cfg_ch` = 0.
  - Stimulus: third frame.
  - Required response: read 0xABC ^ 0x800 = 0x2BC.
- Protocol error during CONV:
  - Stimulus: 2 SCK pulses while `conv_busy` = 1.
  - Required response: 4 `proto_err` pulses (one per edge); the following frame still reads the correct code and `frame_done` fires.
- Abort mid-frame:
  - Stimulus: CONVST rise after 4 SCK cycles in SHIFT.
  - Required response: no `frame_done`; `cfg_*` unchanged (fewer than 6 rises seen); `conv_busy` re-asserts; the next full frame reads the selected channel.
- Reset mid-frame:
  - Stimulus: `reset` asserted after 7 SCK cycles of a frame with SDI = 111110.
  - Required response: `adc_sdo` = 0, `cfg_ch` = 0, `cfg_uni` = 1, no `frame_done`.
- Channel sweep:
  - Stimulus: channel n = 0x100·n + n, for n = 0..7; select each channel in turn.
  - Required response: every one of the 8 channel codes is returned on the frame after it is selected.

Source files
------------

// File: rtl/ltc2308_emulator.sv
// LTC2308 SPI ADC responder: returns preset channel codes over CONVST/SCK/SDI/SDO.
// A config word shifted in during a frame selects the channel for the next conversion.
module ltc2308_emulator #(
  parameter int unsigned CONV_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adc_convst,
  input  logic        adc_sck,
  input  logic        adc_sdi,
  output logic        adc_sdo,
  input  logic [95:0] sample_data,
  output logic [2:0]  cfg_ch,
  output logic        cfg_diff,
  output logic        cfg_uni,
  output logic        cfg_slp,
  output logic        conv_busy,
  output logic        frame_done,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  localparam logic [5:0] CFG_RST = 6'b100010;

  state_e      state_q, state_d;
  logic [2:0]  cv_q, cv_d;
  logic [2:0]  sck_q, sck_d;
  logic [1:0]  sdi_q, sdi_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [11:0] code_q, code_d;
  logic [5:0]  cfg_q, cfg_d;
  logic [5:0]  pend_q, pend_d;
  logic [2:0]  rise_cnt_q, rise_cnt_d;
  logic        sdo_q, sdo_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        proto_err_q, proto_err_d;

  logic        cv_rise, sck_rise, sck_fall, sck_edge;
  logic        start;
  logic [5:0]  cfg_eff;
  logic [2:0]  ch_sel;
  logic [11:0] code_sel;
  logic [3:0]  idx_nx;
  logic [11:0] chan [8];

  for (genvar i = 0; i < 8; i++) begin : g_chan
    assign chan[i] = sample_data[12*i +: 12];
  end

  assign cv_rise  = cv_q[1] & ~cv_q[2];
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign sck_edge = sck_rise | sck_fall;
  assign idx_nx   = idx_q - 4'd1;

  // An abort after a full config word commits it before the new capture
  always_comb begin
    cfg_eff = cfg_q;
    if (state_q == SHIFT && rise_cnt_q == 3'd6) cfg_eff = pend_q;
    ch_sel   = {cfg_eff[3], cfg_eff[2], cfg_eff[4]};
    code_sel = chan[ch_sel];
    if (!cfg_eff[1]) code_sel[11] = ~code_sel[11];
  end

  always_comb begin
    cv_d         = {cv_q[1:0], adc_convst};
    sck_d        = {sck_q[1:0], adc_sck};
    sdi_d        = {sdi_q[0], adc_sdi};
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    code_d       = code_q;
    cfg_d        = cfg_q;
    pend_d       = pend_q;
    rise_cnt_d   = rise_cnt_q;
    sdo_d        = sdo_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    proto_err_d  = 1'b0;
    start        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cv_rise) start = 1'b1;
        else if (sck_edge) proto_err_d = 1'b1;
      end
      CONV: begin
        if (sck_edge) proto_err_d = 1'b1;
        if (cnt_q <= 10'd1) begin
          state_d = SHIFT;
          busy_d  = 1'b0;
          sdo_d   = code_q[11];
          idx_d   = 4'd11;
        end else begin
          cnt_d = cnt_q - 10'd1;
        end
      end
      SHIFT: begin
        if (cv_rise) begin
          cfg_d = cfg_eff;
          start = 1'b1;
        end else if (sck_rise) begin
          if (rise_cnt_q < 3'd6) begin
            pend_d     = {pend_q[4:0], sdi_q[1]};
            rise_cnt_d = rise_cnt_q + 3'd1;
          end
        end else if (sck_fall) begin
          if (idx_q == 4'd0) begin
            state_d      = IDLE;
            sdo_d        = 1'b0;
            frame_done_d = 1'b1;
            if (rise_cnt_q == 3'd6) cfg_d = pend_q;
          end else begin
            idx_d = idx_nx;
            sdo_d = code_q[idx_nx];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d    = CONV;
      code_d     = code_sel;
      cnt_d      = 10'(CONV_CYCLES);
      busy_d     = 1'b1;
      sdo_d      = 1'b0;
      rise_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cv_q         <= '0;
      sck_q        <= '0;
      sdi_q        <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      code_q       <= '0;
      cfg_q        <= CFG_RST;
      pend_q       <= '0;
      rise_cnt_q   <= '0;
      sdo_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cv_q         <= cv_d;
      sck_q        <= sck_d;
      sdi_q        <= sdi_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      code_q       <= code_d;
      cfg_q        <= cfg_d;
      pend_q       <= pend_d;
      rise_cnt_q   <= rise_cnt_d;
      sdo_q        <= sdo_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign adc_sdo    = sdo_q;
  assign conv_busy  = busy_q;
  assign frame_done = frame_done_q;
  assign proto_err  = proto_err_q;
  assign cfg_ch     = {cfg_q[3], cfg_q[2], cfg_q[4]};
  assign cfg_diff   = ~cfg_q[5];
  assign cfg_uni    = cfg_q[1];
  assign cfg_slp    = cfg_q[0];

endmodule

// File: tb/tb_ltc2308_emulator.sv
// Directed bench for ltc2308_emulator: acts as the SPI master.
// Inputs change and outputs are sampled on falling clk edges.
module tb_ltc2308_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        adc_convst;
  logic        adc_sck;
  logic        adc_sdi;
  logic        adc_sdo;
  logic [95:0] sample_data;
  logic [2:0]  cfg_ch;
  logic        cfg_diff, cfg_uni, cfg_slp;
  logic        conv_busy, frame_done, proto_err;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int pe_cnt = 0;

  always #5 clk = ~clk;

  ltc2308_emulator dut (
    .clk(clk), .reset(reset),
    .adc_convst(adc_convst), .adc_sck(adc_sck),
    .adc_sdi(adc_sdi), .adc_sdo(adc_sdo),
    .sample_data(sample_data),
    .cfg_ch(cfg_ch), .cfg_diff(cfg_diff),
    .cfg_uni(cfg_uni), .cfg_slp(cfg_slp),
    .conv_busy(conv_busy), .frame_done(frame_done),
    .proto_err(proto_err)
  );

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (proto_err) pe_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // {S/D,O/S,S1,S0,UNI,SLP} for single-ended unipolar channel ch
  function automatic logic [5:0] cfg_word(input logic [2:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
  endfunction

  task automatic start_conv(input string tag);
    int n;
    n = 0;
    adc_convst = 1'b1;
    while (!conv_busy && n < 50) begin
      clks(1);
      n++;
    end
    chk(tag, 32'(conv_busy), 32'd1);
    adc_convst = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (conv_busy && n < 300) begin
      clks(1);
      n++;
    end
    chk(tag, 32'(conv_busy), 32'd0);
  endtask

  task automatic frame(input logic [5:0] cfg, input int nsck,
                       output logic [11:0] rd);
    rd = '0;
    for (int i = 0; i < nsck; i++) begin
      adc_sdi = (i < 6) ? cfg[5-i] : 1'b0;
      clks(4);
      adc_sck = 1'b1;
      clks(8);
      rd = {rd[10:0], adc_sdo};
      adc_sck = 1'b0;
      clks(8);
    end
    adc_sdi = 1'b0;
    clks(8);
  endtask

  logic [11:0] rd;
  int fd0, pe0;

  initial begin
    reset       = 1'b1;
    adc_convst  = 1'b0;
    adc_sck     = 1'b0;
    adc_sdi     = 1'b0;
    sample_data = '0;
    sample_data[11:0]  = 12'hABC;
    sample_data[23:12] = 12'h123;
    clks(5);
    chk("rst_sdo", 32'(adc_sdo), 32'd0);
    chk("rst_busy", 32'(conv_busy), 32'd0);
    chk("rst_ch", 32'(cfg_ch), 32'd0);
    chk("rst_uni", 32'(cfg_uni), 32'd1);
    chk("rst_diff", 32'(cfg_diff), 32'd0);
    chk("rst_slp", 32'(cfg_slp), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    reset = 1'b0;
    clks(5);

    // basic frame
    fd0 = fd_cnt;
    start_conv("b_busy_rise");
    wait_done("b_busy_fall");
    frame(6'b110010, 12, rd);
    chk("b_read", 32'(rd), 32'hABC);
    chk("b_fd", 32'(fd_cnt - fd0), 32'd1);
    chk("b_ch", 32'(cfg_ch), 32'd1);
    chk("b_uni", 32'(cfg_uni), 32'd1);
    chk("b_sdo_idle", 32'(adc_sdo), 32'd0);

    // config applies to next conversion
    start_conv("n_busy_rise");
    wait_done("n_busy_fall");
    frame(6'b100000, 12, rd);
    chk("n_read", 32'(rd), 32'h123);
    chk("n_uni", 32'(cfg_uni), 32'd0);
    chk("n_ch", 32'(cfg_ch), 32'd0);
    start_conv("t_busy_rise");
    wait_done("t_busy_fall");
    frame(6'b100010, 12, rd);
    chk("t_read_bipolar", 32'(rd), 32'h2BC);
    chk("t_uni", 32'(cfg_uni), 32'd1);

    // SCK during conversion
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    start_conv("p_busy_rise");
    for (int i = 0; i < 2; i++) begin
      adc_sck = 1'b1;
      clks(4);
      adc_sck = 1'b0;
      clks(4);
    end
    clks(4);
    chk("p_proto_cnt", 32'(pe_cnt - pe0), 32'd4);
    wait_done("p_busy_fall");
    frame(6'b100010, 12, rd);
    chk("p_read", 32'(rd), 32'hABC);
    chk("p_fd", 32'(fd_cnt - fd0), 32'd1);

    // abort after 4 SCK cycles
    start_conv("a_busy_rise");
    wait_done("a_busy_fall");
    fd0 = fd_cnt;
    frame(6'b110110, 4, rd);
    start_conv("a_busy_reassert");
    chk("a_fd", 32'(fd_cnt - fd0), 32'd0);
    chk("a_ch", 32'(cfg_ch), 32'd0);
    chk("a_uni", 32'(cfg_uni), 32'd1);
    wait_done("a_busy_fall2");
    frame(6'b100010, 12, rd);
    chk("a_read", 32'(rd), 32'hABC);
    chk("a_fd2", 32'(fd_cnt - fd0), 32'd1);

    // reset mid-frame
    start_conv("r_busy_rise");
    wait_done("r_busy_fall");
    fd0 = fd_cnt;
    frame(6'b111110, 7, rd);
    reset = 1'b1;
    clks(2);
    chk("r_sdo", 32'(adc_sdo), 32'd0);
    chk("r_busy", 32'(conv_busy), 32'd0);
    chk("r_ch", 32'(cfg_ch), 32'd0);
    chk("r_uni", 32'(cfg_uni), 32'd1);
    chk("r_fd", 32'(fd_cnt - fd0), 32'd0);
    reset = 1'b0;
    clks(5);

    // channel sweep: each frame selects the next channel
    for (int n = 0; n < 8; n++)
      sample_data[12*n +: 12] = 12'(32'h100 * n + n);
    for (int n = 0; n < 8; n++) begin
      logic [2:0] nx;
      nx = 3'(n + 1);
      start_conv("s_busy_rise");
      wait_done("s_busy_fall");
      frame(cfg_word(nx), 12, rd);
      chk($sformatf("s_read_ch%0d", n), 32'(rd),
          32'h100 * n + n);
      chk($sformatf("s_cfg_ch%0d", nx), 32'(cfg_ch), 32'(nx));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
